// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the keypad scan controller.
// Key codes are sized for the 4x4 matrix.
package keypad_pkg;

  function automatic int key_idx_w(input int cols, input int rows);
    return (cols * rows > 1) ? $clog2(cols * rows) : 1;
  endfunction

  localparam int KEY_CODE_W = key_idx_w(4, 4);

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    SAMPLE,
    EVAL
  } scan_state_t;

  typedef struct packed {
    logic [KEY_CODE_W-1:0] code;
    logic                  pressed;
  } key_event_t;

endpackage

// File: rtl/keypad_event_fifo.sv
// keypad_event_fifo: show-ahead FIFO of key events.
// Ports: clk/rst_n, push/din, pop/dout, empty, overflow (dropped push).
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int Depth = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  key_event_t din,
  input  logic       pop,
  output key_event_t dout,
  output logic       empty,
  output logic       overflow
);

  localparam int AW = $clog2(Depth);

  key_event_t    mem [Depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          do_pop;
  logic          do_push;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(Depth);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full push needs
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)
        count <= count + (AW+1)'(1);
      else if (do_pop && !do_push)
        count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/keypad_scan_controller.sv
// keypad_scan_controller: column-scanned, debounced key matrix front end.
// Ports: Clock/ResetN, Enable, ColumnPins (out, active low), RowPins (in,
// active low), KeyValid/KeyReady/KeyCode/KeyPressed event port, Overflow.
// Define KEYPAD_REPEAT_EN to auto-repeat a single held key.
module keypad_scan_controller
  import keypad_pkg::*;
#(
  parameter int ColumnHeight     = 4,
  parameter int RowWidth         = 4,
  parameter int ScanDivider      = 1000,
  parameter int SettleCycles     = 8,
  parameter int DebounceScans    = 4,
  parameter int FifoDepth        = 4,
  parameter int RepeatDelayScans = 50,
  parameter int RepeatRateScans  = 10,
  localparam int KW = key_idx_w(ColumnHeight, RowWidth)
) (
  input  logic                    Clock,
  input  logic                    ResetN,
  input  logic                    Enable,
  output logic [ColumnHeight-1:0] ColumnPins,
  input  logic [RowWidth-1:0]     RowPins,
  output logic                    KeyValid,
  input  logic                    KeyReady,
  output logic [KW-1:0]           KeyCode,
  output logic                    KeyPressed,
  output logic                    Overflow
);

  localparam int N  = ColumnHeight * RowWidth;
  localparam int CW = (ColumnHeight > 1) ? $clog2(ColumnHeight) : 1;
  localparam int SW = $clog2(ScanDivider);
  // step is cleared in DRIVE, so it reads k-1 in slot cycle k
  localparam logic [SW-1:0] SETTLE_END = SW'(SettleCycles - 1);
  localparam logic [SW-1:0] SAMPLE_AT  = SW'(SettleCycles);
  localparam logic [SW-1:0] SLOT_END   = SW'(ScanDivider - 2);
  localparam logic [3:0]    DB_LAST    = 4'(DebounceScans - 1);

  // marker scope for unsupported parameter sets; nothing is built inside
  if (ScanDivider < SettleCycles + 4 || SettleCycles < 1 ||
      DebounceScans < 1 || DebounceScans > 15 || FifoDepth < 2 ||
      RepeatDelayScans < 1 || RepeatRateScans < 1) begin : g_bad_params
  end

  scan_state_t         state;
  scan_state_t         state_n;
  logic [CW-1:0]       col;
  logic [SW-1:0]       step;
  logic [KW-1:0]       eidx;
  logic [RowWidth-1:0] sync1;
  logic [RowWidth-1:0] sync2;
  logic [N-1:0]        raw;
  logic [N-1:0]        stable;
  logic [3:0]          cnt [N];
  logic                last_col;
  logic                eval_last;
  logic                key_raw;
  logic                key_stable;
  logic                key_flip;
  logic                rep_push;
  logic                push;
  logic                pop;
  logic                empty;
  key_event_t          ev;
  key_event_t          head;

  assign last_col   = col == CW'(ColumnHeight - 1);
  assign eval_last  = eidx == KW'(N - 1);
  assign key_raw    = raw[eidx];
  assign key_stable = stable[eidx];
  assign key_flip   = state == EVAL && key_raw != key_stable &&
                      cnt[eidx] == DB_LAST;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (Enable) state_n = DRIVE;
      DRIVE:   state_n = SETTLE;
      SETTLE:  if (step == SETTLE_END) state_n = SAMPLE;
      SAMPLE:  if (step == SLOT_END) state_n = last_col ? EVAL : DRIVE;
      EVAL:    if (eval_last) state_n = Enable ? DRIVE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ColumnPins = '1;
    if (state == DRIVE || state == SETTLE || state == SAMPLE)
      ColumnPins[col] = 1'b0;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      sync1 <= '1;
      sync2 <= '1;
      col   <= '0;
      step  <= '0;
      eidx  <= '0;
      raw   <= '0;
    end else begin
      sync1 <= RowPins;
      sync2 <= sync1;
      unique case (state)
        IDLE:   col  <= '0;
        DRIVE:  step <= '0;
        SETTLE: step <= step + SW'(1);
        SAMPLE: begin
          step <= step + SW'(1);
          if (step == SAMPLE_AT)
            raw[int'(col) * RowWidth +: RowWidth] <= ~sync2;
          if (step == SLOT_END)
            col <= last_col ? '0 : col + CW'(1);
        end
        EVAL:   eidx <= eval_last ? '0 : eidx + KW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      stable <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else if (state == EVAL) begin
      if (key_raw == key_stable) begin
        cnt[eidx] <= '0;
      end else if (key_flip) begin
        stable[eidx] <= ~key_stable;
        cnt[eidx]    <= '0;
      end else begin
        cnt[eidx] <= cnt[eidx] + 4'd1;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  logic [15:0] rep_cnt;
  logic [15:0] rep_target;
  logic        rep_armed;
  logic        rep_fire;
  logic        frame_chg;
  logic        one_pressed;

  assign one_pressed = $onehot(stable);
  assign rep_target  = rep_armed ? 16'(RepeatRateScans - 1)
                                 : 16'(RepeatDelayScans - 1);
  // the fire decision is made at frame end, emitted at the key's slot
  assign rep_push = state == EVAL && rep_fire && one_pressed &&
                    key_stable && key_raw;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
      rep_fire  <= 1'b0;
      frame_chg <= 1'b0;
    end else if (state == EVAL) begin
      if (key_flip) frame_chg <= 1'b1;
      if (eval_last) begin
        frame_chg <= 1'b0;
        rep_fire  <= 1'b0;
        if (frame_chg || key_flip || !one_pressed) begin
          rep_cnt   <= '0;
          rep_armed <= 1'b0;
        end else if (rep_cnt >= rep_target) begin
          rep_cnt   <= '0;
          rep_armed <= 1'b1;
          rep_fire  <= 1'b1;
        end else begin
          rep_cnt <= rep_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign rep_push = 1'b0;
`endif

  always_comb begin
    ev         = '0;
    ev.code    = KEY_CODE_W'(eidx);
    ev.pressed = key_flip ? ~key_stable : 1'b1;
  end

  assign push = key_flip | rep_push;
  assign pop  = KeyValid & KeyReady;

  keypad_event_fifo #(
    .Depth(FifoDepth)
  ) u_fifo (
    .clk     (Clock),
    .rst_n   (ResetN),
    .push    (push),
    .din     (ev),
    .pop     (pop),
    .dout    (head),
    .empty   (empty),
    .overflow(Overflow)
  );

  assign KeyValid   = ~empty;
  assign KeyCode    = empty ? '0 : KW'(head.code);
  assign KeyPressed = ~empty & head.pressed;

endmodule

// File: tb/tb_keypad_scan_controller.sv
// tb_keypad_scan_controller: directed bench for keypad_scan_controller.
// Ideal 4x4 matrix model drives RowPins from ColumnPins and held keys.
module tb_keypad_scan_controller;

  logic       Clock;
  logic       ResetN;
  logic       Enable;
  logic [3:0] ColumnPins;
  logic [3:0] RowPins;
  logic       KeyValid;
  logic       KeyReady;
  logic [3:0] KeyCode;
  logic       KeyPressed;
  logic       Overflow;

  logic [15:0] keys;
  logic [3:0]  rows;
  logic        force_rows;
  logic [3:0]  row_ovr;

  int errs;
  int checks;
  int ovf_cnt = 0;

  keypad_scan_controller #(
    .ColumnHeight (4),
    .RowWidth     (4),
    .ScanDivider  (16),
    .SettleCycles (4),
    .DebounceScans(2),
    .FifoDepth    (4)
  ) dut (
    .Clock     (Clock),
    .ResetN    (ResetN),
    .Enable    (Enable),
    .ColumnPins(ColumnPins),
    .RowPins   (RowPins),
    .KeyValid  (KeyValid),
    .KeyReady  (KeyReady),
    .KeyCode   (KeyCode),
    .KeyPressed(KeyPressed),
    .Overflow  (Overflow)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always_comb begin
    rows = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !ColumnPins[c]) rows[r] = 1'b0;
    RowPins = force_rows ? row_ovr : rows;
  end

  always @(negedge Clock) if (Overflow) ovf_cnt++;

  typedef struct {
    int         off;
    logic [3:0] col;
  } walk_t;

  typedef struct {
    int         key;
    logic [3:0] code;
    int         lat;
  } key_t;

  walk_t walk [11];
  key_t  ktab [4];
  int    exp_code [3];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame();
    logic [3:0] last;
    bit found;
    last  = ColumnPins;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge Clock);
      if (ColumnPins == 4'b1110 && last == 4'b1111) found = 1;
      last = ColumnPins;
    end
    if (!found) chk("frame_sync_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!KeyValid && n < 400) begin
      @(negedge Clock);
      n++;
    end
  endtask

  task automatic pop_one();
    KeyReady = 1'b1;
    @(negedge Clock);
    KeyReady = 1'b0;
  endtask

  initial begin
    int  n;
    int  cur;
    int  base;
    bit  seen;
    bit  hold_ok;

    walk[0]  = '{0,  4'b1110};
    walk[1]  = '{15, 4'b1110};
    walk[2]  = '{16, 4'b1101};
    walk[3]  = '{31, 4'b1101};
    walk[4]  = '{32, 4'b1011};
    walk[5]  = '{47, 4'b1011};
    walk[6]  = '{48, 4'b0111};
    walk[7]  = '{63, 4'b0111};
    walk[8]  = '{64, 4'b1111};
    walk[9]  = '{79, 4'b1111};
    walk[10] = '{80, 4'b1110};
    // latency = 80 + 64 + key + 1 from the frame-start DRIVE cycle
    ktab[0] = '{9,  4'd9,  154};
    ktab[1] = '{0,  4'd0,  145};
    ktab[2] = '{15, 4'd15, 160};
    ktab[3] = '{6,  4'd6,  151};
    exp_code[0] = 3;
    exp_code[1] = 15;
    exp_code[2] = 4;

    errs = 0;
    checks = 0;
    ResetN = 1'b1;
    Enable = 1'b1;
    KeyReady = 1'b0;
    keys = '0;
    force_rows = 1'b1;
    row_ovr = 4'h0;
    #2 ResetN = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      row_ovr = 4'(i * 5 + 3);
      chk("reset_cols", ColumnPins, 4'b1111);
      chk("reset_valid", KeyValid, 0);
    end
    chk("reset_code", KeyCode, 0);
    chk("reset_pressed", KeyPressed, 0);
    chk("reset_ovf", Overflow, 0);

    force_rows = 1'b0;
    @(negedge Clock);
    ResetN = 1'b1;
    wait_frame();
    cur = 0;
    for (int i = 0; i < 11; i++) begin
      while (cur < walk[i].off) begin
        @(negedge Clock);
        cur++;
      end
      chk($sformatf("walk_%0d", walk[i].off), ColumnPins, walk[i].col);
    end

    for (int v = 0; v < 4; v++) begin
      wait_frame();
      keys[ktab[v].key] = 1'b1;
      wait_valid(n);
      chk($sformatf("press_lat_k%0d", ktab[v].key), n, ktab[v].lat);
      chk("press_code", KeyCode, ktab[v].code);
      chk("press_flag", KeyPressed, 1);
      pop_one();
      chk("press_popped", KeyValid, 0);
      wait_frame();
      keys[ktab[v].key] = 1'b0;
      wait_valid(n);
      chk($sformatf("rel_lat_k%0d", ktab[v].key), n, ktab[v].lat);
      chk("rel_code", KeyCode, ktab[v].code);
      chk("rel_flag", KeyPressed, 0);
      pop_one();
      chk("rel_popped", KeyValid, 0);
    end

    wait_frame();
    keys[5] = 1'b1;
    repeat (80) @(negedge Clock);
    keys[5] = 1'b0;
    seen = 0;
    for (int i = 0; i < 320; i++) begin
      @(negedge Clock);
      if (KeyValid) seen = 1;
    end
    chk("glitch_no_event", seen, 0);

    wait_frame();
    keys[0] = 1'b1;
    keys[3] = 1'b1;
    keys[15] = 1'b1;
    wait_valid(n);
    chk("multi_first_lat", n, 145);
    hold_ok = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge Clock);
      if (KeyCode !== 4'd0 || KeyPressed !== 1'b1) hold_ok = 0;
    end
    chk("hold_stable", hold_ok, 1);

    wait_frame();
    keys[4] = 1'b1;
    keys[8] = 1'b1;
    base = ovf_cnt;
    repeat (200) @(negedge Clock);
    chk("overflow_once", ovf_cnt - base, 1);

    wait_frame();
    keys[8] = 1'b0;
    base = ovf_cnt;
    repeat (152) @(negedge Clock);
    chk("full_head_code", KeyCode, 0);
    chk("full_valid", KeyValid, 1);
    pop_one();
    repeat (17) @(negedge Clock);
    chk("pop_push_no_ovf", ovf_cnt - base, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("drain_code_%0d", i), KeyCode, exp_code[i]);
      chk("drain_flag", KeyPressed, 1);
      pop_one();
    end
    chk("drain_last_code", KeyCode, 8);
    chk("drain_last_flag", KeyPressed, 0);

    keys = '0;
    wait_frame();
    repeat (2) @(negedge Clock);
    chk("pre_reset_valid", KeyValid, 1);
    ResetN = 1'b0;
    #1;
    chk("mid_reset_cols", ColumnPins, 4'b1111);
    chk("mid_reset_valid", KeyValid, 0);
    chk("mid_reset_code", KeyCode, 0);
    chk("mid_reset_pressed", KeyPressed, 0);
    chk("mid_reset_ovf", Overflow, 0);
    @(negedge Clock);
    ResetN = 1'b1;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge Clock);
      if (KeyValid) seen = 1;
    end
    chk("post_reset_no_event", seen, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_controller.md
# keypad_scan_controller

Sequencing controller for the row/column key matrix. Drives one active-low column at a time, samples the active-low row pins after a settle delay, debounces every key across full-matrix scans, and emits press/release events through a small FIFO with a valid/ready handshake. It sits between the matrix pins and the calculator's input logic, replacing free-running scan-clock decoding with a single-clock, debounced event source.

## Interface
- ColumnHeight, 4: number of column lines.
- RowWidth, 4: number of row lines.
- ScanDivider, 1000: clocks per column step; must be ≥ SettleCycles+4.
- SettleCycles, 8: clocks after a column change before rows are sampled.
- DebounceScans, 4: consecutive full scans a key must differ from its stable state before it flips; range 1–15.
- FifoDepth, 4: event FIFO entries; power of two.
- RepeatDelayScans, 50 / RepeatRateScans, 10: used only with KEYPAD_REPEAT_EN.
- Clock  in  1  system clock, all logic on posedge.
- ResetN  in  1  asynchronous active-low reset.
- Enable  in  1  scanning enable.
- ColumnPins  out  ColumnHeight  column drive, active low, one-cold.
- RowPins  in  RowWidth  row sense, active low, asynchronous to Clock.
- KeyValid  out  1  event available.
- KeyReady  in  1  consumer accepts event.
- KeyCode  out  $clog2(ColumnHeight*RowWidth)  key index = col*RowWidth + row.
- KeyPressed  out  1  1 = press, 0 = release.
- Overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- RowPins pass through a 2-flop synchronizer before any use.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, EVAL.
- IDLE: ColumnPins all 1; column index 0; go to DRIVE when Enable=1.
- DRIVE (1 cycle): ColumnPins = ~(1<<col); step counter cleared.
- SETTLE: count to SettleCycles; then SAMPLE.
- SAMPLE (1 cycle): raw[col*RowWidth+r] = ~syncRow[r]. Wait out the remainder of ScanDivider, then DRIVE with col+1. After the last column go to EVAL; col wraps to 0.
- EVAL: exactly ColumnHeight*RowWidth cycles, one key per cycle, index ascending. Per key: if raw == stable, count clears to 0; else count increments. When count reaches DebounceScans, stable flips, count clears, and event {index, new stable} is pushed.
- After EVAL: DRIVE if Enable=1, else IDLE. Enable deassertion mid-frame completes the current frame.
- FIFO: show-ahead; KeyValid = !empty; KeyCode/KeyPressed = head entry. Pop on KeyValid&KeyReady.
- Push when full: dropped, Overflow pulses, stored entries unchanged. Push and pop in the same cycle when full: both occur, no overflow.
- Multi-key presses are reported individually; no ghost suppression.

## Timing
- Reset values: ColumnPins all 1, KeyValid 0, KeyCode 0, KeyPressed 0, Overflow 0, FIFO empty, all stable = released, all counts 0, FSM IDLE.
- Sample instant: SettleCycles+1 clocks after the DRIVE cycle. Row-to-sample latency includes 2 synchronizer cycles.
- Frame period: ColumnHeight*ScanDivider + ColumnHeight*RowWidth clocks.
- Press latency: DebounceScans frames after first sampled press. The event enters the FIFO in the EVAL cycle for that key. KeyValid rises on the following clock if the FIFO was empty.
- KeyCode/KeyPressed are held stable while KeyValid=1 and KeyReady=0.
- Reset mid-frame: immediate return to reset values; pending events are lost.

## Configuration
- KEYPAD_REPEAT_EN defined: after a key's stable press lasts RepeatDelayScans frames, an additional press event is pushed every RepeatRateScans frames until release. Repeat applies only while exactly one key is stable-pressed; the repeat counter restarts on any stable change.
- Not defined: events only on stable transitions. Repeat parameters are ignored and no repeat logic is built.

## Structure
- Package keypad_pkg:
  - state enum scan_state_t (IDLE, DRIVE, SETTLE, SAMPLE, EVAL).
  - struct key_event_t {code, pressed}.
  - localparam function for the key index width.
- Sub-module keypad_event_fifo: parameterized show-ahead FIFO of key_event_t with push/pop/full/empty/overflow.

## Test plan
Bench parameters: ScanDivider=16, SettleCycles=4, DebounceScans=2, FifoDepth=4.
- Reset held, RowPins toggling -> ColumnPins=4'b1111, KeyValid=0. After release with Enable=1 -> ColumnPins walks 1110,1101,1011,0111 with 16-clock steps.
- Hold row 1 low only while column 2 is driven -> exactly one event, KeyCode=9, KeyPressed=1, after the 2nd frame. Releasing gives KeyCode=9, KeyPressed=0 two frames later.
- Single-frame glitch on key 5 -> no event.
- Press keys 0,3,15 simultaneously with KeyReady=0 -> events in order 0,3,15. A 5th pending event with FIFO full -> Overflow pulses once and the FIFO content is unchanged.
- KeyReady=0 for 20 clocks with an event pending -> KeyCode/KeyPressed unchanged. Full FIFO with simultaneous pop and push -> no Overflow.
- Assert ResetN low mid-SETTLE with an event queued -> all outputs return to reset values within the same cycle.
